// File: rtl/mul_seq.sv
// mul_seq: multi-cycle signed integer multiplier, radix-2 shift-add.
//
// The block takes the magnitudes of both two's-complement operands and adds
// shifted copies of |A| for every set bit of |B|. It runs exactly B_WIDTH
// iterations whatever the operand values are. The sign is applied in a single
// final step. The product is full width (P_WIDTH = A_WIDTH + B_WIDTH), so it
// never overflows and can feed the companion divider without truncation.
//
// Ports:
//   clk          in   rising-edge clock
//   reset        in   asynchronous, active-low reset
//   valid_in     in   operands valid; accepted when in_ready is also high
//   in_ready     out  block is idle and can accept operands
//   multiplicand in   signed operand A  [A_WIDTH]
//   multiplier   in   signed operand B  [B_WIDTH]
//   product      out  signed A*B [P_WIDTH], registered, held until next result
//   valid_out    out  one-cycle pulse: product was updated on the last edge
//
// Timing: the cycle in which valid_out is high begins B_WIDTH+1 edges after
// the acceptance edge. A valid_in held high through DONE is accepted on the
// next IDLE edge, which gives one result every B_WIDTH+3 cycles.

module mul_seq #(
  parameter int A_WIDTH = 32,
  parameter int B_WIDTH = 32,
  parameter int P_WIDTH = A_WIDTH + B_WIDTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               valid_in,
  output logic               in_ready,
  input  logic [A_WIDTH-1:0] multiplicand,
  input  logic [B_WIDTH-1:0] multiplier,
  output logic [P_WIDTH-1:0] product,
  output logic               valid_out
);

  localparam int CNT_W = (B_WIDTH > 1) ? $clog2(B_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(B_WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    SIGN,
    DONE
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [A_WIDTH-1:0] mag_a;   // |A|, unsigned; holds 2^(A_WIDTH-1) exactly
  logic [B_WIDTH-1:0] shf_b;   // |B|, consumed LSB first
  logic               sign_q;
  logic [P_WIDTH-1:0] acc;
  logic [CNT_W-1:0]   count;

  logic               accept;
  logic [A_WIDTH-1:0] abs_a;
  logic [B_WIDTH-1:0] abs_b;
  logic [P_WIDTH-1:0] addend;

  assign accept = valid_in && (state_q == IDLE);

  // Unary minus of the most-negative value wraps to itself, and read as an
  // unsigned value that is the correct magnitude 2^(W-1).
  assign abs_a = multiplicand[A_WIDTH-1] ? -multiplicand : multiplicand;
  assign abs_b = multiplier[B_WIDTH-1]   ? -multiplier   : multiplier;

  // The magnitude is zero-extended before the shift, so no bits are lost for
  // any count up to B_WIDTH-1.
  assign addend = P_WIDTH'(mag_a) << count;

  // NOTE: state and datapath registers use non-blocking assignments so every
  // register samples the values from before the edge, whatever order the
  // statements are written in.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: every output of this block gets a default before the case, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    valid_out = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (valid_in) state_d = RUN;
      end
      RUN: begin
        if (count == LAST_CNT) state_d = SIGN;
      end
      SIGN: begin
        state_d = DONE;
      end
      DONE: begin
        valid_out = 1'b1;
        state_d   = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mag_a   <= '0;
      shf_b   <= '0;
      sign_q  <= 1'b0;
      acc     <= '0;
      count   <= '0;
      product <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            mag_a  <= abs_a;
            shf_b  <= abs_b;
            sign_q <= multiplicand[A_WIDTH-1] ^ multiplier[B_WIDTH-1];
            acc    <= '0;
            count  <= '0;
          end
        end
        RUN: begin
          if (shf_b[0]) acc <= acc + addend;
          shf_b <= shf_b >> 1;
          count <= count + CNT_W'(1);
        end
        SIGN: begin
          // A zero accumulator negates to zero, so the result is never -0.
          product <= sign_q ? -acc : acc;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_seq.sv
// tb_mul_seq: self-checking bench for mul_seq (default 32x32 -> 64).
// Expected products come from a 64-bit signed reference multiply. They are
// pushed to a scoreboard queue when operands are accepted and popped when
// valid_out pulses.

module tb_mul_seq;

  localparam int A_W = 32;
  localparam int B_W = 32;
  localparam int P_W = 64;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic           valid_in = 1'b0;
  logic [A_W-1:0] multiplicand = '0;
  logic [B_W-1:0] multiplier = '0;
  logic           in_ready;
  logic           valid_out;
  logic [P_W-1:0] product;

  int checks = 0;
  int failures = 0;
  int cycle = 0;

  logic [P_W-1:0] exp_q[$];

  mul_seq #(
    .A_WIDTH(A_W),
    .B_WIDTH(B_W),
    .P_WIDTH(P_W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .valid_in(valid_in),
    .in_ready(in_ready),
    .multiplicand(multiplicand),
    .multiplier(multiplier),
    .product(product),
    .valid_out(valid_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
    $fatal(1, "watchdog expired");
  end

  function automatic logic [P_W-1:0] model(input logic [A_W-1:0] a, input logic [B_W-1:0] b);
    longint sa;
    longint sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    return P_W'(sa * sb);
  endfunction

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Presents operands and returns just after the acceptance edge. The expected
  // product enters the scoreboard when the handshake completes.
  task automatic accept(input logic [A_W-1:0] a, input logic [B_W-1:0] b);
    logic ok;
    ok = 1'b0;
    multiplicand = a;
    multiplier   = b;
    valid_in     = 1'b1;
    for (int i = 0; i < 80 && !ok; i++) begin
      if (in_ready) begin
        ok = 1'b1;
        exp_q.push_back(model(a, b));
      end
      step();
    end
    valid_in = 1'b0;
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL accept_timeout: in_ready never high, a=%h b=%h", a, b);
    end
  endtask

  // Waits (bounded) for valid_out. lat counts the acceptance edge as 1 when
  // called right after accept().
  task automatic wait_result(output logic seen, output int lat, output logic [P_W-1:0] got);
    seen = 1'b0;
    lat  = 1;
    got  = '0;
    for (int i = 0; i < 80; i++) begin
      if (valid_out) begin
        seen = 1'b1;
        got  = product;
        break;
      end
      step();
      lat++;
    end
  endtask

  function automatic logic [P_W-1:0] pop_expected();
    if (exp_q.size() == 0) return 'x;
    return exp_q.pop_front();
  endfunction

  task automatic test_reset();
    reset = 1'b0;
    step(2);
    checks++;
    if (product !== '0) begin
      failures++;
      $display("FAIL reset_product: got=%h exp=0", product);
    end
    checks++;
    if (valid_out !== 1'b0) begin
      failures++;
      $display("FAIL reset_valid_out: got=%b exp=0", valid_out);
    end
    reset = 1'b1;
    step();
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_in_ready: got=%b exp=1", in_ready);
    end
  endtask

  task automatic test_basic();
    logic           seen;
    int             lat;
    logic [P_W-1:0] got;
    logic [P_W-1:0] exp;
    accept(32'd7, -32'sd3);
    wait_result(seen, lat, got);
    exp = pop_expected();
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL basic_timeout: no valid_out");
    end
    checks++;
    if (lat !== 34) begin
      failures++;
      $display("FAIL basic_latency: got=%0d exp=34", lat);
    end
    checks++;
    if (got !== exp || got !== 64'hFFFF_FFFF_FFFF_FFEB) begin
      failures++;
      $display("FAIL basic_product: got=%h exp=%h", got, exp);
    end
    step();
    checks++;
    if (valid_out !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL basic_after_done: valid_out=%b in_ready=%b exp 0/1", valid_out, in_ready);
    end
    step(5);
    checks++;
    if (product !== exp) begin
      failures++;
      $display("FAIL basic_hold: got=%h exp=%h", product, exp);
    end
  endtask

  task automatic test_extremes();
    logic [A_W-1:0] ta[6] = '{32'h8000_0000, 32'h8000_0000, 32'h0, 32'hFFFF_FFFF,
                              32'h7FFF_FFFF, 32'h7FFF_FFFF};
    logic [B_W-1:0] tb[6] = '{32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFFB, 32'h1,
                              32'h7FFF_FFFF, 32'h8000_0000};
    logic           seen;
    int             lat;
    logic [P_W-1:0] got;
    logic [P_W-1:0] exp;
    for (int i = 0; i < 6; i++) begin
      accept(ta[i], tb[i]);
      wait_result(seen, lat, got);
      exp = pop_expected();
      checks++;
      if (!seen || got !== exp) begin
        failures++;
        $display("FAIL extreme_%0d: a=%h b=%h seen=%b got=%h exp=%h", i, ta[i], tb[i], seen, got, exp);
      end
      step();
    end
  endtask

  task automatic test_random();
    logic [A_W-1:0] a;
    logic [B_W-1:0] b;
    logic           seen;
    int             lat;
    logic [P_W-1:0] got;
    logic [P_W-1:0] exp;
    for (int i = 0; i < 5; i++) begin
      a = $urandom();
      b = $urandom();
      accept(a, b);
      wait_result(seen, lat, got);
      exp = pop_expected();
      checks++;
      if (!seen || got !== exp) begin
        failures++;
        $display("FAIL random_%0d: a=%h b=%h seen=%b got=%h exp=%h", i, a, b, seen, got, exp);
      end
      step();
    end
  endtask

  task automatic test_ignore_busy();
    logic           seen;
    int             lat;
    logic [P_W-1:0] got;
    logic [P_W-1:0] exp;
    int             extra;
    accept(32'd3, 32'd4);
    step(3);
    multiplicand = 32'd100;
    multiplier   = 32'd100;
    valid_in     = 1'b1;
    step();
    valid_in = 1'b0;
    wait_result(seen, lat, got);
    exp = pop_expected();
    checks++;
    if (!seen || got !== exp || got !== 64'd12) begin
      failures++;
      $display("FAIL busy_product: seen=%b got=%h exp=%h", seen, got, exp);
    end
    extra = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (valid_out) extra++;
    end
    checks++;
    if (extra !== 0) begin
      failures++;
      $display("FAIL busy_extra_valid: got=%0d pulses exp=0", extra);
    end
  endtask

  task automatic test_back_to_back();
    logic           seen;
    int             lat;
    logic [P_W-1:0] got;
    logic [P_W-1:0] exp;
    int             t1;
    int             t2;
    accept(32'd11, -32'sd13);
    multiplicand = -32'sd6;
    multiplier   = -32'sd7;
    valid_in     = 1'b1;
    wait_result(seen, lat, got);
    t1  = cycle;
    exp = pop_expected();
    checks++;
    if (!seen || got !== exp) begin
      failures++;
      $display("FAIL b2b_first: seen=%b got=%h exp=%h", seen, got, exp);
    end
    step();
    checks++;
    if (in_ready !== 1'b1 || valid_out !== 1'b0) begin
      failures++;
      $display("FAIL b2b_idle: in_ready=%b valid_out=%b exp 1/0", in_ready, valid_out);
    end
    exp_q.push_back(model(-32'sd6, -32'sd7));
    step();
    valid_in = 1'b0;
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL b2b_accept: in_ready=%b exp=0", in_ready);
    end
    wait_result(seen, lat, got);
    t2  = cycle;
    exp = pop_expected();
    checks++;
    if (!seen || got !== exp || got !== 64'd42) begin
      failures++;
      $display("FAIL b2b_second: seen=%b got=%h exp=%h", seen, got, exp);
    end
    checks++;
    if (t2 - t1 !== 35) begin
      failures++;
      $display("FAIL b2b_spacing: got=%0d exp=35", t2 - t1);
    end
    step();
  endtask

  task automatic test_reset_abort();
    logic           seen;
    int             lat;
    logic [P_W-1:0] got;
    logic [P_W-1:0] exp;
    int             pulses;
    accept(32'd5, 32'd9);
    step(9);
    reset = 1'b0;
    #1;
    checks++;
    if (product !== '0 || valid_out !== 1'b0) begin
      failures++;
      $display("FAIL abort_in_reset: product=%h valid_out=%b exp 0/0", product, valid_out);
    end
    step(2);
    reset = 1'b1;
    exp_q.delete();
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL abort_in_ready: got=%b exp=1", in_ready);
    end
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      if (valid_out) pulses++;
      step();
    end
    checks++;
    if (pulses !== 0 || product !== '0) begin
      failures++;
      $display("FAIL abort_no_result: pulses=%0d product=%h exp 0/0", pulses, product);
    end
    accept(32'd2, 32'd2);
    wait_result(seen, lat, got);
    exp = pop_expected();
    checks++;
    if (!seen || got !== exp || got !== 64'd4) begin
      failures++;
      $display("FAIL abort_fresh: seen=%b got=%h exp=%h", seen, got, exp);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_extremes();
    test_ignore_busy();
    test_back_to_back();
    test_reset_abort();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
